// File: rtl/ysyx_25020037_axi_rd_arbiter.sv
// Two-master AXI read-channel arbiter (IFU=m0, LSU=m1) with R watchdog.
// Define YSYX_25020037_ARB_RR_EN for round-robin; default is fixed LSU priority.
module ysyx_25020037_axi_rd_arbiter #(
  parameter int unsigned TMO_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_arvalid,
  input  logic [31:0] m0_araddr,
  input  logic [3:0]  m0_arid,
  input  logic [7:0]  m0_arlen,
  input  logic [2:0]  m0_arsize,
  input  logic [1:0]  m0_arburst,
  output logic        m0_arready,
  output logic        m0_rvalid,
  output logic [1:0]  m0_rresp,
  output logic [31:0] m0_rdata,
  output logic        m0_rlast,
  output logic [3:0]  m0_rid,
  input  logic        m0_rready,
  input  logic        m1_arvalid,
  input  logic [31:0] m1_araddr,
  input  logic [3:0]  m1_arid,
  input  logic [7:0]  m1_arlen,
  input  logic [2:0]  m1_arsize,
  input  logic [1:0]  m1_arburst,
  output logic        m1_arready,
  output logic        m1_rvalid,
  output logic [1:0]  m1_rresp,
  output logic [31:0] m1_rdata,
  output logic        m1_rlast,
  output logic [3:0]  m1_rid,
  input  logic        m1_rready,
  output logic        s_arvalid,
  output logic [31:0] s_araddr,
  output logic [3:0]  s_arid,
  output logic [7:0]  s_arlen,
  output logic [2:0]  s_arsize,
  output logic [1:0]  s_arburst,
  input  logic        s_arready,
  input  logic        s_rvalid,
  input  logic [1:0]  s_rresp,
  input  logic [31:0] s_rdata,
  input  logic        s_rlast,
  input  logic [3:0]  s_rid,
  output logic        s_rready
);

  localparam int WW = (TMO_CYCLES < 2) ? 1 : $clog2(TMO_CYCLES + 1);
  localparam logic [WW-1:0] TMO_W = WW'(TMO_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    ERR
  } state_e;

  state_e          state_q, state_d;
  logic            gnt_q, gnt_d;
  logic [3:0]      rid_q, rid_d;
  logic [WW-1:0]   wdog_q, wdog_d;
`ifdef YSYX_25020037_ARB_RR_EN
  logic            last_q, last_d;
`endif

  logic            pick;
  logic            g_arvalid;
  logic [31:0]     g_araddr;
  logic [3:0]      g_arid;
  logic [7:0]      g_arlen;
  logic [2:0]      g_arsize;
  logic [1:0]      g_arburst;
  logic            g_rready;

  assign g_arvalid = gnt_q ? m1_arvalid : m0_arvalid;
  assign g_araddr  = gnt_q ? m1_araddr  : m0_araddr;
  assign g_arid    = gnt_q ? m1_arid    : m0_arid;
  assign g_arlen   = gnt_q ? m1_arlen   : m0_arlen;
  assign g_arsize  = gnt_q ? m1_arsize  : m0_arsize;
  assign g_arburst = gnt_q ? m1_arburst : m0_arburst;
  assign g_rready  = gnt_q ? m1_rready  : m0_rready;

`ifdef YSYX_25020037_ARB_RR_EN
  // On contention the master that lost last time wins.
  assign pick = (m0_arvalid && m1_arvalid) ? ~last_q : m1_arvalid;
`else
  assign pick = m1_arvalid;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      rid_q   <= 4'd0;
      wdog_q  <= '0;
`ifdef YSYX_25020037_ARB_RR_EN
      last_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rid_q   <= rid_d;
      wdog_q  <= wdog_d;
`ifdef YSYX_25020037_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rid_d      = rid_q;
    wdog_d     = wdog_q;
`ifdef YSYX_25020037_ARB_RR_EN
    last_d     = last_q;
`endif
    s_arvalid  = 1'b0;
    s_araddr   = 32'd0;
    s_arid     = 4'd0;
    s_arlen    = 8'd0;
    s_arsize   = 3'd0;
    s_arburst  = 2'd0;
    s_rready   = 1'b0;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    m0_rdata   = s_rdata;
    m1_rdata   = s_rdata;
    m0_rresp   = s_rresp;
    m1_rresp   = s_rresp;
    m0_rid     = s_rid;
    m1_rid     = s_rid;
    m0_rlast   = 1'b0;
    m1_rlast   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (m0_arvalid || m1_arvalid) begin
          gnt_d   = pick;
`ifdef YSYX_25020037_ARB_RR_EN
          last_d  = pick;
`endif
          state_d = ADDR;
        end
      end
      ADDR: begin
        s_arvalid  = g_arvalid;
        s_araddr   = g_araddr;
        s_arid     = g_arid;
        s_arlen    = g_arlen;
        s_arsize   = g_arsize;
        s_arburst  = g_arburst;
        m0_arready = !gnt_q && s_arready;
        m1_arready = gnt_q && s_arready;
        if (g_arvalid && s_arready) begin
          state_d = DATA;
          wdog_d  = '0;
          rid_d   = g_arid;
        end
      end
      DATA: begin
        s_rready  = g_rready;
        m0_rvalid = !gnt_q && s_rvalid;
        m1_rvalid = gnt_q && s_rvalid;
        m0_rlast  = s_rlast;
        m1_rlast  = s_rlast;
        if (s_rvalid && g_rready) begin
          wdog_d = '0;
          if (s_rlast) state_d = IDLE;
        end else if (!s_rvalid) begin
          // Master back-pressure is not a slave timeout; only empty cycles count.
          wdog_d = (wdog_q == TMO_W) ? wdog_q : wdog_q + WW'(1);
          if (wdog_d == TMO_W) state_d = ERR;
        end
      end
      ERR: begin
        m0_rvalid = !gnt_q;
        m1_rvalid = gnt_q;
        m0_rdata  = 32'd0;
        m1_rdata  = 32'd0;
        m0_rresp  = 2'b10;
        m1_rresp  = 2'b10;
        m0_rid    = rid_q;
        m1_rid    = rid_q;
        m0_rlast  = 1'b1;
        m1_rlast  = 1'b1;
        if (g_rready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (rst) begin
      s_arvalid  = 1'b0;
      s_araddr   = 32'd0;
      s_arid     = 4'd0;
      s_arlen    = 8'd0;
      s_arsize   = 3'd0;
      s_arburst  = 2'd0;
      s_rready   = 1'b0;
      m0_arready = 1'b0;
      m1_arready = 1'b0;
      m0_rvalid  = 1'b0;
      m1_rvalid  = 1'b0;
    end
  end

endmodule

// File: tb/tb_ysyx_25020037_axi_rd_arbiter.sv
// Scoreboard bench for the AXI read arbiter.
// Define YSYX_25020037_ARB_RR_EN to exercise round-robin grants.
module tb_ysyx_25020037_axi_rd_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]        mv, mrr;
  logic [1:0][31:0]  ma;
  logic [1:0][3:0]   mid;
  logic [1:0][7:0]   ml;
  logic [1:0][2:0]   ms;
  logic [1:0][1:0]   mb;
  logic [1:0]        ar_rdy, rv, rl;
  logic [1:0][31:0]  rd;
  logic [1:0][1:0]   rr;
  logic [1:0][3:0]   ri;

  logic        s_arvalid, s_arready, s_rvalid, s_rlast, s_rready;
  logic [31:0] s_araddr, s_rdata;
  logic [3:0]  s_arid, s_rid;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst, s_rresp;

  ysyx_25020037_axi_rd_arbiter #(.TMO_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .m0_arvalid(mv[0]), .m0_araddr(ma[0]), .m0_arid(mid[0]),
    .m0_arlen(ml[0]), .m0_arsize(ms[0]), .m0_arburst(mb[0]),
    .m0_arready(ar_rdy[0]), .m0_rvalid(rv[0]), .m0_rresp(rr[0]),
    .m0_rdata(rd[0]), .m0_rlast(rl[0]), .m0_rid(ri[0]),
    .m0_rready(mrr[0]),
    .m1_arvalid(mv[1]), .m1_araddr(ma[1]), .m1_arid(mid[1]),
    .m1_arlen(ml[1]), .m1_arsize(ms[1]), .m1_arburst(mb[1]),
    .m1_arready(ar_rdy[1]), .m1_rvalid(rv[1]), .m1_rresp(rr[1]),
    .m1_rdata(rd[1]), .m1_rlast(rl[1]), .m1_rid(ri[1]),
    .m1_rready(mrr[1]),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_arready(s_arready), .s_rvalid(s_rvalid), .s_rresp(s_rresp),
    .s_rdata(s_rdata), .s_rlast(s_rlast), .s_rid(s_rid),
    .s_rready(s_rready)
  );

  typedef struct packed {
    logic        m;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rexp_t;

  typedef struct packed {
    logic        m;
    logic [31:0] addr;
    logic [3:0]  id;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } arexp_t;

  rexp_t  rq[$];
  arexp_t aq[$];
  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic arexp_t mk_ar(input logic m, input logic [31:0] a,
                                   input logic [3:0] id,
                                   input logic [7:0] len);
    return '{m: m, addr: a, id: id, len: len, size: 3'd2, burst: 2'b01};
  endfunction

  // Monitor: pops expectations whenever the DUT completes a handshake.
  always @(negedge clk) begin
    if (!rst) begin
      for (int m = 0; m < 2; m++) begin
        if (rv[m] && mrr[m]) begin
          if (rq.size() == 0) chk("r_unexpected", 64'(m), 64'hFF);
          else begin
            rexp_t e;
            e = rq.pop_front();
            chk("r_beat", 64'({m[0], rd[m], rr[m], rl[m], ri[m]}), 64'(e));
          end
        end
      end
      if (s_arvalid && s_arready) begin
        chk("ar_onehot", 64'(ar_rdy[0] ^ ar_rdy[1]), 64'd1);
        if (aq.size() == 0) chk("ar_unexpected", 64'(s_araddr), 64'hFF);
        else begin
          arexp_t e;
          e = aq.pop_front();
          chk("ar_req", 64'({ar_rdy[1], s_araddr, s_arid, s_arlen,
                             s_arsize, s_arburst}), 64'(e));
        end
      end
    end
  end

  task automatic mreq(input int m, input logic [31:0] a,
                      input logic [3:0] id, input logic [7:0] len);
    bit ok;
    ok = 0;
    ma[m] = a; mid[m] = id; ml[m] = len;
    ms[m] = 3'd2; mb[m] = 2'b01; mv[m] = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ar_rdy[m] && s_arready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    mv[m] = 1'b0;
    if (!ok) chk("ar_timeout", 64'(m), 64'hFF);
  endtask

  task automatic wait_ar();
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (s_arvalid && s_arready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    if (!ok) chk("wait_ar_timeout", 64'd0, 64'd1);
  endtask

  task automatic sbeat(input int m, input logic [31:0] d, input logic last,
                       input int gap, input logic [3:0] id);
    bit ok;
    ok = 0;
    repeat (gap) begin @(posedge clk); #1; end
    s_rvalid = 1'b1; s_rdata = d; s_rlast = last; s_rid = id;
    s_rresp = 2'b00;
    rq.push_back('{m: m[0], data: d, resp: 2'b00, last: last, id: id});
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (s_rready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    s_rvalid = 1'b0; s_rlast = 1'b0;
    if (!ok) chk("r_timeout", 64'(d), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got time %0t expected finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    mv = '0; mrr = 2'b11; ma = '0; mid = '0; ml = '0; ms = '0; mb = '0;
    s_arready = 1'b1; s_rvalid = 1'b0; s_rdata = '0; s_rlast = 1'b0;
    s_rid = '0; s_rresp = '0;
    mv[0] = 1'b1; ma[0] = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    chk("rst_outs", 64'({s_arvalid, s_rready, rv, ar_rdy, s_araddr,
                          s_arid, s_arlen}), 64'd0);
    @(posedge clk); #1;
    mv = '0; rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // IFU-only burst, AR latency
    aq.push_back(mk_ar(1'b0, 32'hA000_0000, 4'd3, 8'd3));
    fork
      mreq(0, 32'hA000_0000, 4'd3, 8'd3);
      begin
        @(negedge clk); chk("ar_lat0", 64'(s_arvalid), 64'd0);
        @(negedge clk); chk("ar_lat1", 64'(s_arvalid), 64'd1);
      end
      begin
        wait_ar();
        for (int i = 0; i < 4; i++)
          sbeat(0, 32'h1000 + i, i == 3, 0, 4'd3);
      end
    join
    @(negedge clk);
    chk("idle_after", 64'({s_arvalid, s_rready, rv}), 64'd0);
    @(posedge clk); #1;

`ifdef YSYX_25020037_ARB_RR_EN
    aq.push_back(mk_ar(1'b1, 32'h8000_0010, 4'd1, 8'd0));
    aq.push_back(mk_ar(1'b0, 32'h8000_0030, 4'd3, 8'd0));
    aq.push_back(mk_ar(1'b1, 32'h8000_0020, 4'd2, 8'd0));
    aq.push_back(mk_ar(1'b0, 32'h8000_0040, 4'd4, 8'd0));
    fork
      begin
        mreq(1, 32'h8000_0010, 4'd1, 8'd0);
        mreq(1, 32'h8000_0020, 4'd2, 8'd0);
      end
      begin
        mreq(0, 32'h8000_0030, 4'd3, 8'd0);
        mreq(0, 32'h8000_0040, 4'd4, 8'd0);
      end
      begin
        wait_ar(); sbeat(1, 32'h11, 1'b1, 0, 4'd1);
        wait_ar(); sbeat(0, 32'h33, 1'b1, 0, 4'd3);
        wait_ar(); sbeat(1, 32'h22, 1'b1, 0, 4'd2);
        wait_ar(); sbeat(0, 32'h44, 1'b1, 0, 4'd4);
      end
    join
`else
    aq.push_back(mk_ar(1'b1, 32'h8000_0100, 4'd5, 8'd1));
    aq.push_back(mk_ar(1'b0, 32'h8000_0200, 4'd6, 8'd0));
    fork
      mreq(0, 32'h8000_0200, 4'd6, 8'd0);
      mreq(1, 32'h8000_0100, 4'd5, 8'd1);
      begin
        wait_ar();
        sbeat(1, 32'h5150, 1'b0, 0, 4'd5);
        sbeat(1, 32'h5151, 1'b1, 1, 4'd5);
        wait_ar();
        sbeat(0, 32'h6060, 1'b1, 0, 4'd6);
      end
    join
`endif
    @(posedge clk); #1;

    // Watchdog: slave silent after AR
    aq.push_back(mk_ar(1'b1, 32'h0F00_0000, 4'd9, 8'd0));
    rq.push_back('{m: 1'b1, data: 32'd0, resp: 2'b10, last: 1'b1, id: 4'd9});
    fork
      mreq(1, 32'h0F00_0000, 4'd9, 8'd0);
      begin
        int n;
        wait_ar();
        n = 0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (rv[1]) break;
          n++;
        end
        chk("wdog_cycles", 64'(n), 64'd8);
        chk("err_rready", 64'(s_rready), 64'd0);
      end
    join
    @(posedge clk); #1;
    @(negedge clk);
    chk("err_done", 64'({rv, s_rready}), 64'd0);
    @(posedge clk); #1;

    // Reset mid-burst
    aq.push_back(mk_ar(1'b0, 32'h3000_0000, 4'd7, 8'd3));
    fork
      mreq(0, 32'h3000_0000, 4'd7, 8'd3);
      begin
        wait_ar();
        sbeat(0, 32'h7000, 1'b0, 0, 4'd7);
        sbeat(0, 32'h7001, 1'b0, 0, 4'd7);
        s_rvalid = 1'b1; s_rdata = 32'h7002; s_rid = 4'd7;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_outs", 64'({s_arvalid, s_rready, rv, ar_rdy}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; s_rvalid = 1'b0;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (i % 3 == 0) chk("no_err_beat", 64'({rv, s_rready}), 64'd0);
        end
        @(posedge clk); #1;
      end
    join
    aq.push_back(mk_ar(1'b0, 32'h3000_1000, 4'd2, 8'd1));
    fork
      mreq(0, 32'h3000_1000, 4'd2, 8'd1);
      begin
        wait_ar();
        sbeat(0, 32'h7100, 1'b0, 0, 4'd2);
        sbeat(0, 32'h7101, 1'b1, 0, 4'd2);
      end
    join
    @(posedge clk); #1;

    // Master stall mid-burst with a preceding slave gap
    aq.push_back(mk_ar(1'b0, 32'h4000_0000, 4'd8, 8'd3));
    fork
      mreq(0, 32'h4000_0000, 4'd8, 8'd3);
      begin
        wait_ar();
        sbeat(0, 32'h8000, 1'b0, 0, 4'd8);
        sbeat(0, 32'h8001, 1'b0, 0, 4'd8);
        mrr[0] = 1'b0;
        fork
          sbeat(0, 32'h8002, 1'b0, 4, 4'd8);
          begin
            for (int i = 0; i < 20; i++) begin
              @(negedge clk);
              if (s_rvalid) break;
            end
            chk("stall_rready", 64'({s_rready, rv[0]}), 64'b01);
            repeat (4) begin
              @(negedge clk);
              chk("stall_rready", 64'({s_rready, rv[0]}), 64'b01);
            end
            @(posedge clk); #1;
            mrr[0] = 1'b1;
          end
        join
        sbeat(0, 32'h8003, 1'b1, 0, 4'd8);
      end
    join
    repeat (3) begin @(posedge clk); #1; end

    chk("rq_empty", 64'(rq.size()), 64'd0);
    chk("aq_empty", 64'(aq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
